// File: rtl/turbo_puncture_serializer.sv
// Buffers 3-bit turbo codewords and serializes them as sys/par1/par2 bits, with optional rate-1/2 puncturing and frame markers.
// Latency: push at edge N into an empty FIFO -> first bit valid after edge N+1. The bit stream stalls on !bit_ready, and cw_ready drops only when the FIFO is full.
module turbo_puncture_serializer #(
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] cw_in,
    input  logic       cw_valid,
    output logic       cw_ready,
    input  logic       punct_en,
    output logic       bit_out,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       bit_sof,
    output logic       frame_done,
    output logic       overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYS,
        ST_PAR1,
        ST_PAR2
    } state_t;

    logic [2:0]    fifo_mem_q [DEPTH];
    logic [2:0]    fifo_mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    state_t        state_q, state_d;
    logic [2:0]    cw_q, cw_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          punct_q, punct_d;
    logic          bit_out_q, bit_out_d;
    logic          bit_valid_q, bit_valid_d;
    logic          bit_sof_q, bit_sof_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;

    logic          full, empty, push, pop, hs, cw_end;
    logic [2:0]    head;
    logic [IW-1:0] idx_next;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign hs    = bit_valid_q & bit_ready;

    assign cw_ready   = rst_n & ~full;
    assign push       = cw_valid & cw_ready;
    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign bit_sof    = bit_sof_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q | (cw_valid & ~cw_ready);
        if (push) begin
            fifo_mem_d[wr_ptr_q[AW-1:0]] = cw_in;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        cw_d         = cw_q;
        idx_d        = idx_q;
        punct_d      = punct_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = bit_valid_q;
        bit_sof_d    = bit_sof_q;
        frame_done_d = 1'b0;
        pop          = 1'b0;
        cw_end       = 1'b0;
        idx_next     = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (!empty) pop = 1'b1;
            end
            ST_SYS: begin
                if (hs) begin
                    bit_sof_d = 1'b0;
                    // Punctured odd codewords skip par1 and carry par2 instead.
                    if (!punct_q || !idx_q[0]) begin
                        state_d   = ST_PAR1;
                        bit_out_d = cw_q[1];
                    end else begin
                        state_d   = ST_PAR2;
                        bit_out_d = cw_q[2];
                    end
                end
            end
            ST_PAR1: begin
                if (hs) begin
                    if (!punct_q) begin
                        state_d   = ST_PAR2;
                        bit_out_d = cw_q[2];
                    end else begin
                        cw_end = 1'b1;
                    end
                end
            end
            ST_PAR2: begin
                if (hs) cw_end = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (cw_end) begin
            idx_next     = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            idx_d        = idx_next;
            frame_done_d = (idx_q == IDX_LAST);
            if (!empty) begin
                pop = 1'b1;
            end else begin
                state_d     = ST_IDLE;
                bit_valid_d = 1'b0;
                bit_out_d   = 1'b0;
                bit_sof_d   = 1'b0;
            end
        end

        // Puncture mode is frozen for the whole frame at its first codeword.
        if (pop) begin
            state_d     = ST_SYS;
            cw_d        = head;
            bit_out_d   = head[0];
            bit_valid_d = 1'b1;
            bit_sof_d   = (idx_next == '0);
            if (idx_next == '0) punct_d = punct_en;
        end

        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= ST_IDLE;
            cw_q         <= '0;
            idx_q        <= '0;
            punct_q      <= 1'b0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            bit_sof_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            cw_q         <= cw_d;
            idx_q        <= idx_d;
            punct_q      <= punct_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            bit_sof_q    <= bit_sof_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end
endmodule
